ee457_fetch_unit: RTL
=====================

Name: ee457_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the ee457 pipelined CPU family. It replaces the single PC register and IF/ID latch with a PC generator and an N-entry prefetch queue.
- Handles variable-latency instruction memory through a valid handshake, decode back-pressure, and a single redirect port for branch, jump and JR resolution from later stages.
- Sits between instruction memory and the decode/register-read stage.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- INSTR_W, 32, instruction width. Fixed 32 for MIPS encoding; the parameter exists for the bench only.
- QDEPTH, 4, prefetch queue entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imemread  out  1  fetch request.
- imem_rdata  in  INSTR_W  instruction word, valid when imem_rvalid=1.
- imem_rvalid  in  1  memory returns the word for imem_addr this cycle.
- if_valid  out  1  queue head holds an instruction.
- if_instr  out  INSTR_W  head instruction; 0 (NOP) when empty.
- if_pc_plus4  out  ADDR_W  head instruction's PC+4.
- if_pred_taken  out  1  head was predicted taken (0 when feature off or empty).
- id_stall  in  1  decode not accepting (load-use stall).
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address.
- fetch_misalign  out  1  sticky flag: a redirect_pc with nonzero [1:0] was received.

Behaviour:
- Reset (async): pc=RESET_PC; count=0; head and tail pointers=0; fetch_misalign=0; all queue entries invalid; if_valid=0, if_instr=0, if_pc_plus4=0, if_pred_taken=0. imemread=0 while rst=1.
- pop = if_valid & ~id_stall & ~redirect.
- room = (count<QDEPTH) | pop.
- imemread = room & ~redirect & ~rst.
- imem_addr=pc, held stable until imem_rvalid is seen.
- push = imemread & imem_rvalid. On push:
  - write {imem_rdata, pc+4, pred} at tail.
  - pc <= next fetch pc (pc+4, or the predicted target when the feature is on).
- Count update: count += push − pop. Simultaneous push and pop at full is legal; count stays at QDEPTH.
- Pointers are log2(QDEPTH) bits and wrap naturally. Full = count==QDEPTH; empty = count==0.
- Zero-bubble path: if the queue is empty, a pushed word appears at the head on the next cycle. Fetch-to-decode latency is 1 cycle minimum.
- Head outputs are combinational from the head entry; if_valid = (count!=0).
- Redirect has highest priority:
  - on the clock edge, count<=0 and pointers<=0.
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - any imem response in the same cycle is discarded.
  - no pop occurs.
  - if redirect_pc[1:0]!=0, fetch_misalign<=1 (cleared only by rst).
- Fetch resumes from the new pc on the cycle after redirect.
- id_stall while empty has no effect.
- PC arithmetic is modulo 2^ADDR_W: pc=all-ones−3 wraps to 0.
- Reset asserted mid-stall or mid-wait returns to reset state immediately (async).

Optional Feature:
- Macro: EE457_FETCH_PREDICT_EN.
- Defined: static backward-taken prediction. On push, if opcode is OP_BEQ or OP_BNE and imm[15]==1:
  - pc <= pc+4+(sext(imm)<<2).
  - the entry's pred bit is set to 1.
  - the stored pc_plus4 is still pc+4.
- Later stages must redirect to pc_plus4 on a wrong prediction.
- Not defined: pc always advances by 4, pred bits tie to 0, no decode logic is synthesised.

Decomposition:
- Shared package ee457_pkg:
  - opcode localparams (OP_BEQ, OP_BNE, OP_JMP, OP_JAL, …).
  - NOP encoding constant.
  - fetch-entry field widths.
- One sub-module: ee457_fetch_fifo, a parametrised synchronous FIFO with count, async reset, flush input, and same-cycle push/pop at full. The PC and prediction logic stay in the top.

Test Plan:
- Reset release, imem_rvalid=1 every cycle, id_stall=0 → imem_addr 0,4,8,…; if_instr follows memory one cycle later; if_pc_plus4 = 4,8,12.
- id_stall=1 held 6 cycles, QDEPTH=4 → exactly 4 pushes, then imemread=0 and imem_addr frozen at 0x10. Release → head pops 0x0..0xC in order with no loss or duplication.
- imem_rvalid toggled 1-0-0-1 → imem_addr held during the 0 cycles; no entry pushed while rvalid=0.
- redirect=1, redirect_pc=0x40 while queue holds 3 entries and imem_rvalid=1 → next cycle if_valid=0; following fetch addr 0x40; the discarded word never appears.
- redirect_pc=0x42 → fetch from 0x40; fetch_misalign=1 and stays 1 through further redirects until rst.
- With EE457_FETCH_PREDICT_EN: BEQ at 0x20 with imm=0xFFFE → next fetch 0x1C; head if_pred_taken=1, if_pc_plus4=0x24. Without the macro → next fetch 0x24, pred=0.

Source files
------------

// File: rtl/ee457_pkg.sv
// Shared definitions for the ee457 pipelined CPU family: MIPS opcodes, NOP encoding
// and fetch-queue entry field widths.
package ee457_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int IMM_W      = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // sll $0,$0,0 is the canonical MIPS NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int PRED_W = 1;

    function automatic int fetch_entry_w(input int instr_w, input int addr_w);
        return instr_w + addr_w + PRED_W;
    endfunction

endpackage

// File: rtl/ee457_fetch_unit_if.sv
// Bundles the instruction-memory, decode and redirect signals of the fetch stage.
// master = fetch unit side, slave = memory/decode/back-end side.
interface ee457_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imemread;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_rvalid;

    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc_plus4;
    logic               if_pred_taken;
    logic               id_stall;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               fetch_misalign;

    modport master (
        output imem_addr, imemread,
        input  imem_rdata, imem_rvalid,
        output if_valid, if_instr, if_pc_plus4, if_pred_taken,
        input  id_stall,
        input  redirect, redirect_pc,
        output fetch_misalign
    );

    modport slave (
        input  imem_addr, imemread,
        output imem_rdata, imem_rvalid,
        input  if_valid, if_instr, if_pc_plus4, if_pred_taken,
        output id_stall,
        output redirect, redirect_pc,
        input  fetch_misalign
    );

endinterface

// File: rtl/ee457_fetch_fifo.sv
// Synchronous FIFO with occupancy count, async reset, flush, and push+pop while full.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module ee457_fetch_fifo #(
    parameter int DATA_W = 65,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    // a pop in the same cycle frees the slot the push lands in
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // storage carries no reset; entries beyond count are never observed
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail] <= wdata;
    end

    assign rdata = mem[head];
    assign count = cnt;

endmodule

// File: rtl/ee457_fetch_unit.sv
// Instruction-fetch stage: PC generator feeding a QDEPTH-entry prefetch queue.
// Optional static backward-taken branch prediction under `EE457_FETCH_PREDICT_EN.
module ee457_fetch_unit
    import ee457_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    ee457_fetch_unit_if.master  bus
);

    localparam int ENTRY_W = fetch_entry_w(INSTR_W, ADDR_W);
    localparam int CNT_W   = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               pred;
    } entry_t;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  next_pc;
    logic               pred;
    logic               misalign;

    logic               push;
    logic               pop;
    logic               room;
    logic               fetch;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   count;

    entry_t             wentry;
    entry_t             hentry;
    logic [ENTRY_W-1:0] hraw;

    assign pc_plus4 = pc + ADDR_W'(4);

`ifdef EE457_FETCH_PREDICT_EN
    function automatic logic signed [ADDR_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(ADDR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

    logic [5:0]       opcode;
    logic [IMM_W-1:0] imm;
    logic             back_branch;

    assign opcode      = bus.imem_rdata[OPCODE_MSB:OPCODE_LSB];
    assign imm         = bus.imem_rdata[IMM_W-1:0];
    assign back_branch = ((opcode == OP_BEQ) || (opcode == OP_BNE)) && imm[IMM_W-1];
    assign pred        = back_branch;
    assign next_pc     = back_branch ? (pc_plus4 + branch_offset(imm)) : pc_plus4;
`else
    assign pred    = 1'b0;
    assign next_pc = pc_plus4;
`endif

    // handshake: redirect blocks both pop and fetch for this cycle
    assign full  = (count == CNT_W'(QDEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & ~bus.id_stall & ~bus.redirect;
    assign room  = ~full | pop;
    assign fetch = room & ~bus.redirect & ~rst;
    assign push  = fetch & bus.imem_rvalid;

    assign wentry = {bus.imem_rdata, pc_plus4, pred};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else if (bus.redirect) begin
            pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            if (bus.redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
        end else if (push) begin
            pc <= next_pc;
        end
    end

    ee457_fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (hraw),
        .count (count)
    );

    assign hentry = hraw;

    // head outputs are forced to a NOP bundle whenever the queue is empty
    assign bus.imem_addr      = pc;
    assign bus.imemread       = fetch;
    assign bus.if_valid       = ~empty;
    assign bus.if_instr       = empty ? INSTR_W'(NOP_INSTR) : hentry.instr;
    assign bus.if_pc_plus4    = empty ? '0 : hentry.pc_plus4;
    assign bus.if_pred_taken  = ~empty & hentry.pred;
    assign bus.fetch_misalign = misalign;

endmodule
